// File: rtl/mux_bist_controller.sv
// mux_bist_controller: built-in self-test sequencer for the 32-bit 2:1
// fault-tolerant mux. It drives LFSR-derived a/b/select vectors and
// compares each mux output against the expected value. It counts data
// mismatches and raised error flags, then reports pass/fail.
// Optional feature macro: MUX_BIST_SIGNATURE_EN adds a MISR over dut_c,
// exposed on the signature output.
module mux_bist_controller #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'h1ACE_B00C,
    parameter logic [31:0] B_MASK      = 32'hA5A5_A5A5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [31:0] bist_a,
    output logic [31:0] bist_b,
    output logic        bist_s,
    input  logic [31:0] dut_c,
    input  logic        dut_err,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] mismatch_cnt,
    output logic [15:0] flag_cnt,
    output logic [19:0] first_fail_idx
`ifdef MUX_BIST_SIGNATURE_EN
    ,
    output logic [31:0] signature
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [19:0] LAST_IDX = 20'(NUM_VECTORS - 1);
    localparam logic [19:0] NO_FAIL  = 20'hF_FFFF;

    // Galois LFSR: shift right, fold in the taps when a 1 falls out
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        logic [31:0] n;
        n = {1'b0, l[31:1]};
        if (l[0]) begin
            n = n ^ 32'h8020_0003;
        end else begin
            n = n;
        end
        return n;
    endfunction

    // Operand b is the halfword-swapped LFSR value scrambled by the mask
    function automatic logic [31:0] derive_b(input logic [31:0] l);
        return {l[15:0], l[31:16]} ^ B_MASK;
    endfunction

    // Saturating increment for the 16-bit event counters
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        logic [15:0] r;
        if (en && (v != 16'hFFFF)) begin
            r = v + 16'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [19:0] vec_idx_q, vec_idx_d;
    logic [31:0] bist_a_q, bist_a_d;
    logic [31:0] bist_b_q, bist_b_d;
    logic        bist_s_q, bist_s_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [15:0] mismatch_cnt_q, mismatch_cnt_d;
    logic [15:0] flag_cnt_q, flag_cnt_d;
    logic [19:0] first_fail_idx_q, first_fail_idx_d;
`ifdef MUX_BIST_SIGNATURE_EN
    logic [31:0] sig_q, sig_d;
`endif

    logic [31:0] expected_s;
    logic        mismatch_s;
    logic [31:0] lfsr_next_s;

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d          = state_q;
        lfsr_d           = lfsr_q;
        vec_idx_d        = vec_idx_q;
        bist_a_d         = bist_a_q;
        bist_b_d         = bist_b_q;
        bist_s_d         = bist_s_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;
        mismatch_cnt_d   = mismatch_cnt_q;
        flag_cnt_d       = flag_cnt_q;
        first_fail_idx_d = first_fail_idx_q;
`ifdef MUX_BIST_SIGNATURE_EN
        sig_d            = sig_q;
`endif
        expected_s  = bist_s_q ? bist_b_q : bist_a_q;
        mismatch_s  = (dut_c != expected_s);
        lfsr_next_s = lfsr_step(lfsr_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    // abort beats start and always lands in IDLE
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else if (start) begin
                    state_d          = ST_RUN;
                    busy_d           = 1'b1;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    mismatch_cnt_d   = 16'd0;
                    flag_cnt_d       = 16'd0;
                    first_fail_idx_d = NO_FAIL;
                    lfsr_d           = SEED;
                    vec_idx_d        = 20'd0;
                    bist_a_d         = SEED;
                    bist_b_d         = derive_b(SEED);
                    bist_s_d         = 1'b0;
`ifdef MUX_BIST_SIGNATURE_EN
                    sig_d            = 32'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // the vector on the aborting edge is dropped, counts freeze
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    bist_a_d = 32'd0;
                    bist_b_d = 32'd0;
                    bist_s_d = 1'b0;
                end else begin
                    mismatch_cnt_d = sat_inc(mismatch_cnt_q, mismatch_s);
                    flag_cnt_d     = sat_inc(flag_cnt_q, dut_err);
                    if ((mismatch_s || dut_err) && (first_fail_idx_q == NO_FAIL)) begin
                        first_fail_idx_d = vec_idx_q;
                    end else begin
                        first_fail_idx_d = first_fail_idx_q;
                    end
`ifdef MUX_BIST_SIGNATURE_EN
                    sig_d = {sig_q[30:0], 1'b0}
                          ^ (sig_q[31] ? 32'h04C1_1DB7 : 32'd0)
                          ^ dut_c;
`endif
                    lfsr_d    = lfsr_next_s;
                    vec_idx_d = vec_idx_q + 20'd1;
                    if (vec_idx_q == LAST_IDX) begin
                        state_d  = ST_DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        // a raised flag with clean data is a latent fault: still fail
                        pass_d   = (mismatch_cnt_d == 16'd0) && (flag_cnt_d == 16'd0);
                        bist_a_d = 32'd0;
                        bist_b_d = 32'd0;
                        bist_s_d = 1'b0;
                    end else begin
                        bist_a_d = lfsr_next_s;
                        bist_b_d = derive_b(lfsr_next_s);
                        bist_s_d = vec_idx_d[0];
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                done_d   = 1'b0;
                pass_d   = 1'b0;
                bist_a_d = 32'd0;
                bist_b_d = 32'd0;
                bist_s_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            lfsr_q           <= SEED;
            vec_idx_q        <= 20'd0;
            bist_a_q         <= 32'd0;
            bist_b_q         <= 32'd0;
            bist_s_q         <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            mismatch_cnt_q   <= 16'd0;
            flag_cnt_q       <= 16'd0;
            first_fail_idx_q <= NO_FAIL;
`ifdef MUX_BIST_SIGNATURE_EN
            sig_q            <= 32'd0;
`endif
        end else begin
            state_q          <= state_d;
            lfsr_q           <= lfsr_d;
            vec_idx_q        <= vec_idx_d;
            bist_a_q         <= bist_a_d;
            bist_b_q         <= bist_b_d;
            bist_s_q         <= bist_s_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            mismatch_cnt_q   <= mismatch_cnt_d;
            flag_cnt_q       <= flag_cnt_d;
            first_fail_idx_q <= first_fail_idx_d;
`ifdef MUX_BIST_SIGNATURE_EN
            sig_q            <= sig_d;
`endif
        end
    end

    assign bist_a         = bist_a_q;
    assign bist_b         = bist_b_q;
    assign bist_s         = bist_s_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign mismatch_cnt   = mismatch_cnt_q;
    assign flag_cnt       = flag_cnt_q;
    assign first_fail_idx = first_fail_idx_q;
`ifdef MUX_BIST_SIGNATURE_EN
    assign signature      = sig_q;
`endif

endmodule

// File: tb/tb_mux_bist_controller.sv
// Testbench for mux_bist_controller: a behavioural mux sits on the bist_*
// outputs, with per-vector fault injection. A reference LFSR model pushes
// the expected vectors and end-of-run results into queues. These are
// popped and compared as the controller presents vectors and finishes.
module tb_mux_bist_controller;

    localparam int          NV    = 16;
    localparam int          NV_SAT = 70000;
    localparam logic [31:0] SEED  = 32'h1ACE_B00C;
    localparam logic [31:0] BMASK = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, dut_err;
    logic [31:0] bist_a, bist_b, dut_c, flip_mask;
    logic        bist_s, busy, done, pass;
    logic [15:0] mismatch_cnt, flag_cnt;
    logic [19:0] first_fail_idx;

    logic        sat_start;
    logic [31:0] sat_a, sat_b;
    logic        sat_s, sat_busy, sat_done, sat_pass;
    logic [15:0] sat_m, sat_f;
    logic [19:0] sat_ffi;
`ifdef MUX_BIST_SIGNATURE_EN
    logic [31:0] sig_main, sig_sat;
`endif

    always #5 clk = ~clk;

    // behavioural mux under test, with a bench-controlled data fault
    assign dut_c = (bist_s ? bist_b : bist_a) ^ flip_mask;

    mux_bist_controller #(.NUM_VECTORS(NV)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .bist_a(bist_a), .bist_b(bist_b), .bist_s(bist_s),
        .dut_c(dut_c), .dut_err(dut_err),
        .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .flag_cnt(flag_cnt),
        .first_fail_idx(first_fail_idx)
`ifdef MUX_BIST_SIGNATURE_EN
        , .signature(sig_main)
`endif
    );

    mux_bist_controller #(.NUM_VECTORS(NV_SAT)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(sat_start), .abort(1'b0),
        .bist_a(sat_a), .bist_b(sat_b), .bist_s(sat_s),
        .dut_c(32'd0), .dut_err(1'b0),
        .busy(sat_busy), .done(sat_done), .pass(sat_pass),
        .mismatch_cnt(sat_m), .flag_cnt(sat_f),
        .first_fail_idx(sat_ffi)
`ifdef MUX_BIST_SIGNATURE_EN
        , .signature(sig_sat)
`endif
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
    } vec_t;

    typedef struct packed {
        logic [15:0] m;
        logic [15:0] f;
        logic [19:0] ffi;
        logic        pass;
    } res_t;

    vec_t vec_q[$];
    res_t res_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] l);
        logic [31:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    // pop the next expected end-of-run result and compare it
    task automatic check_result(input string tag, input logic [15:0] m, input logic [15:0] f,
                                input logic [19:0] ffi, input logic p);
        res_t r;
        if (res_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_noexp: got result with empty scoreboard, required an entry", tag);
        end else begin
            r = res_q.pop_front();
            check_eq({tag, "_mism"}, m, r.m);
            check_eq({tag, "_flag"}, f, r.f);
            check_eq({tag, "_ffi"}, ffi, r.ffi);
            check_eq({tag, "_pass"}, p, r.pass);
        end
    endtask

    // one run of NV vectors; negative indices disable the corresponding event
    task automatic do_run(input string tag, input int flip_vec, input logic [15:0] err_vecs,
                          input int restart_at, input int abort_at, input int rst_at);
        int          stop;
        logic [31:0] l;
        logic [15:0] m, f;
        logic [19:0] ffi;
        vec_t        v;
        res_t        r;
        logic        mis, er;
        stop = NV;
        if (abort_at >= 0) stop = abort_at;
        l = SEED; m = 16'd0; f = 16'd0; ffi = 20'hF_FFFF;
        for (int k = 0; k < NV; k++) begin
            v.a = l;
            v.b = {l[15:0], l[31:16]} ^ BMASK;
            v.s = k[0];
            vec_q.push_back(v);
            if (k < stop) begin
                mis = (k == flip_vec);
                er  = err_vecs[k];
                if (mis) m++;
                if (er) f++;
                if ((mis || er) && ffi == 20'hF_FFFF) ffi = 20'(k);
            end
            l = model_step(l);
        end
        if (rst_at >= 0) r = '{m: 16'd0, f: 16'd0, ffi: 20'hF_FFFF, pass: 1'b0};
        else             r = '{m: m, f: f, ffi: ffi, pass: (abort_at < 0) && m == 16'd0 && f == 16'd0};
        res_q.push_back(r);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < NV; k++) begin
            flip_mask = (k == flip_vec) ? 32'h0000_0020 : 32'd0;
            dut_err   = err_vecs[k];
            start     = (k == restart_at);
            abort     = (k == abort_at);
            rst_n     = !(k == rst_at);
            v = vec_q.pop_front();
            check_eq({tag, "_busy"}, busy, 1'b1);
            check_eq({tag, "_done_low"}, done, 1'b0);
            check_eq({tag, "_a"}, bist_a, v.a);
            check_eq({tag, "_b"}, bist_b, v.b);
            check_eq({tag, "_s"}, bist_s, v.s);
            if (k == 0) check_eq({tag, "_vec0_a"}, bist_a, 32'h1ACE_B00C);
            @(negedge clk);
            if (k == abort_at || k == rst_at) break;
        end
        flip_mask = 32'd0; dut_err = 1'b0; start = 1'b0; abort = 1'b0; rst_n = 1'b1;
        vec_q.delete();
        check_eq({tag, "_busy_end"}, busy, 1'b0);
        check_eq({tag, "_done_end"}, done, (abort_at < 0 && rst_at < 0));
        check_eq({tag, "_a_end"}, bist_a, 32'd0);
        check_eq({tag, "_b_end"}, bist_b, 32'd0);
        check_eq({tag, "_s_end"}, bist_s, 1'b0);
        check_result(tag, mismatch_cnt, flag_cnt, first_fail_idx, pass);
    endtask

    initial begin
        int ncyc;
        int nbusy;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; dut_err = 1'b0;
        flip_mask = 32'd0; sat_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_pass", pass, 1'b0);
        check_eq("rst_mism", mismatch_cnt, 16'd0);
        check_eq("rst_flag", flag_cnt, 16'd0);
        check_eq("rst_ffi", first_fail_idx, 20'hF_FFFF);
        check_eq("rst_a", bist_a, 32'd0);
        check_eq("rst_b", bist_b, 32'd0);
        check_eq("rst_s", bist_s, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        do_run("clean", -1, 16'h0000, -1, -1, -1);
        do_run("flip3", 3, 16'h0000, -1, -1, -1);

        // abort in DONE returns to IDLE, counters hold
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("done_abort_done", done, 1'b0);
        check_eq("done_abort_pass", pass, 1'b0);
        check_eq("done_abort_mism", mismatch_cnt, 16'd1);
        // abort together with start in IDLE: stays IDLE
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check_eq("abort_start_busy", busy, 1'b0);
        check_eq("abort_start_done", done, 1'b0);

        do_run("err2_7", -1, 16'h0084, -1, -1, -1);
        do_run("restart4", -1, 16'h0000, 4, -1, -1);
        do_run("abort5", 3, 16'h0004, -1, 5, -1);
        do_run("rst9", 3, 16'h0004, -1, -1, 9);
        do_run("after_rst", -1, 16'h0000, -1, -1, -1);

        // long run against a stuck-at-0 output: mismatch counter saturates
        res_q.push_back('{m: 16'hFFFF, f: 16'd0, ffi: 20'd0, pass: 1'b0});
        sat_start = 1'b1;
        @(negedge clk);
        sat_start = 1'b0;
        ncyc = 0;
        nbusy = 0;
        while (!sat_done && ncyc < NV_SAT + 100) begin
            if (sat_busy) nbusy++;
            @(negedge clk);
            ncyc++;
        end
        check_eq("sat_done", sat_done, 1'b1);
        check_eq("sat_busy_cycles", nbusy, NV_SAT);
        check_result("sat", sat_m, sat_f, sat_ffi, sat_pass);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_bist_controller.md
Name: mux_bist_controller

Overview:
- Built-in self-test sequencer for the 32-bit 2:1 fault-tolerant mux.
- On request, drives pseudo-random a/b/select vectors into the mux under test and checks each data output against an internally computed expected value.
- Counts data mismatches and raised error_detected flags, then reports pass/fail.
- Sits beside the datapath mux; the mux inputs are switched to bist_* while busy is high (the switching is done outside this block).

Parameters:
- NUM_VECTORS, 256: vectors applied per run; legal range 1..2^20.
- SEED, 32'h1ACE_B00C: LFSR load value; must be nonzero.
- B_MASK, 32'hA5A5_A5A5: XOR mask used to derive operand b.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request; honoured in IDLE and DONE only
- abort  in  1  cancels a run in progress
- bist_a  out  32  mux operand a
- bist_b  out  32  mux operand b
- bist_s  out  1  mux select
- dut_c  in  32  mux data output
- dut_err  in  1  mux error_detected
- busy  out  1  high while in RUN
- done  out  1  high in DONE
- pass  out  1  valid when done=1
- mismatch_cnt  out  16  saturating count of dut_c != expected
- flag_cnt  out  16  saturating count of dut_err=1
- first_fail_idx  out  20  index of the first vector with a mismatch or a flag; 20'hFFFFF if none

Behaviour:
- Reset (rst_n=0 sampled at posedge): state IDLE; all outputs 0, except first_fail_idx=20'hFFFFF. LFSR=SEED. vec_idx=0.
- State IDLE:
  - start=1 -> RUN.
  - On the same edge: clear both counters, set first_fail_idx=FFFFF, load LFSR=SEED, vec_idx=0.
- Stimulus (all registered), for vector k:
  - bist_a = lfsr
  - bist_b = {lfsr[15:0], lfsr[31:16]} ^ B_MASK
  - bist_s = vec_idx[0]
  - Vector 0 is therefore a=SEED, s=0.
- LFSR: 32-bit Galois. Shift right; if the shifted-out bit is 1, XOR with 32'h8020_0003.
- State RUN, every cycle:
  - The DUT is combinational. dut_c/dut_err for vector k are sampled at the edge ending the cycle in which vector k is presented.
  - expected = bist_s ? bist_b : bist_a.
  - mismatch_cnt += (dut_c != expected); flag_cnt += dut_err. Both saturate at 16'hFFFF.
  - If (mismatch or dut_err) and first_fail_idx == FFFFF: first_fail_idx = vec_idx.
  - Advance LFSR; vec_idx++.
- Leaving RUN:
  - After the vector with vec_idx == NUM_VECTORS-1 is evaluated -> DONE; bist_* go to 0 on the same edge.
  - Latency: busy is high for exactly NUM_VECTORS cycles, starting the cycle after start is sampled; done rises the cycle after busy falls.
- State DONE:
  - done=1 held; pass = (mismatch_cnt==0 && flag_cnt==0).
  - Counters and first_fail_idx hold until the next start.
  - start=1 -> restart, exactly as from IDLE (done and pass drop on that edge).
- Simultaneous and boundary events:
  - start during RUN: ignored.
  - abort=1 in RUN -> IDLE: bist_* = 0, busy = 0, done stays 0; counters keep partial values.
  - abort and start in the same cycle while in IDLE or DONE: abort wins, state becomes/stays IDLE.
  - abort in IDLE or DONE otherwise: no effect, except DONE -> IDLE (done and pass cleared).
  - The vector sampled on the aborting edge is not counted.
  - rst_n low at any time overrides everything and gives reset values on the next edge.
- Fault-tolerance note: the mux masks data faults. A run with mismatch_cnt=0 and flag_cnt>0 therefore still fails, because it indicates a latent fault.

Optional Feature:
- Macro: MUX_BIST_SIGNATURE_EN.
- Defined:
  - Adds output signature[31:0], a MISR updated every RUN cycle: sig = {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 0) ^ dut_c.
  - Reset and start clear it to 0; it holds in DONE.
  - Abort freezes it.
  - pass is unaffected.
- Undefined:
  - No signature port and no MISR logic; all other behaviour identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> busy/done/pass=0, counters=0, first_fail_idx=FFFFF, bist_a/b/s=0.
- Fault-free mux, NUM_VECTORS=16, start pulse at cycle T:
  - First vector shows bist_a=1ACEB00C, bist_s=0.
  - busy high for cycles T+1..T+16; done=1 from T+17.
  - pass=1, counters=0, first_fail_idx=FFFFF.
- Bench forces dut_c[5]=1 only on vector 3, where the true bit is 0 -> mismatch_cnt=1, flag_cnt=0, first_fail_idx=3, pass=0.
- Correct dut_c, dut_err forced high on vectors 2 and 7 -> flag_cnt=2, mismatch_cnt=0, first_fail_idx=2, pass=0.
- Control interactions:
  - start pulse at vector 4 -> ignored; run still lasts 16 cycles.
  - abort at vector 5 -> IDLE next cycle, done=0, mismatch_cnt/flag_cnt unchanged from before vector 5.
  - rst_n=0 at vector 9 -> reset values.
- NUM_VECTORS=70000 with dut_c stuck at 0 -> mismatch_cnt saturates at FFFF, pass=0, first_fail_idx = the first vector with nonzero expected value (0).
